// File: rtl/pool_stream_if.sv
// Pixel stream bundle for pool_stream: clock enable, input pixel/qualifier and mode,
// plus the registered pooled result and its strobes.
interface pool_stream_if #(
    parameter int unsigned dataWidth = 8
);
    logic                 ce;
    logic                 valid_in;
    logic [dataWidth-1:0] data_in;
    logic                 avg_mode;
    logic [dataWidth-1:0] data_out;
    logic                 valid_op;
    logic                 end_op;

    modport master (
        output ce, valid_in, data_in, avg_mode,
        input  data_out, valid_op, end_op
    );

    modport slave (
        input  ce, valid_in, data_in, avg_mode,
        output data_out, valid_op, end_op
    );
endinterface

// File: rtl/pool_stream.sv
// Streaming non-overlapping PxP pooling over a WxW raster feature map (signed pixels).
// Define POOL_AVG_EN to build the average datapath selected by avg_mode; otherwise max only.
module pool_stream #(
    parameter int unsigned dataWidth = 8,
    parameter int unsigned W         = 26,
    parameter int unsigned P         = 2
) (
    input  logic         clk,
    input  logic         global_rst,
    pool_stream_if.slave bus
);
    localparam int unsigned LP   = $clog2(P);
    localparam int unsigned NW   = W / P;
    localparam int unsigned SPAN = NW * P;
    localparam int unsigned CW   = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned WCW  = (NW > 1) ? $clog2(NW) : 1;
`ifdef POOL_AVG_EN
    localparam int unsigned AW   = dataWidth + 2 * LP;
`else
    localparam int unsigned AW   = dataWidth;
`endif

    logic [CW-1:0]        col;
    logic [CW-1:0]        row;
    logic signed [AW-1:0] acc_h;
    logic signed [AW-1:0] vbuf [NW];
    logic                 last_r;
`ifdef POOL_AVG_EN
    logic                 avg_r;
`endif

    logic                 accept;
    logic                 in_span;
    logic                 kc_first;
    logic                 kc_last;
    logic                 kr_first;
    logic                 kr_last;
    logic                 col_last;
    logic                 row_last;
    logic                 win_last;
    logic [WCW-1:0]       wc;
    logic signed [AW-1:0] px_ext;
    logic signed [AW-1:0] h_new;
    logic signed [AW-1:0] v_new;
    logic [dataWidth-1:0] result;

    function automatic logic signed [AW-1:0] max2(input logic signed [AW-1:0] a,
                                                   input logic signed [AW-1:0] b);
        return (a > b) ? a : b;
    endfunction

`ifdef POOL_AVG_EN
    function automatic logic signed [AW-1:0] combine(input logic signed [AW-1:0] a,
                                                      input logic signed [AW-1:0] b,
                                                      input logic              m);
        return m ? (a + b) : max2(a, b);
    endfunction
`endif

    // Position decode and combine of the new pixel into row and column partials
    always_comb begin
        accept   = bus.ce && bus.valid_in;
        in_span  = (32'(col) < SPAN) && (32'(row) < SPAN);
        kc_first = (col[LP-1:0] == '0);
        kc_last  = (col[LP-1:0] == LP'(P - 1));
        kr_first = (row[LP-1:0] == '0);
        kr_last  = (row[LP-1:0] == LP'(P - 1));
        col_last = (32'(col) == W - 1);
        row_last = (32'(row) == W - 1);
        win_last = (32'(col) == SPAN - 1) && (32'(row) == SPAN - 1);
        wc       = WCW'(col >> LP);
        px_ext   = AW'($signed(bus.data_in));
`ifdef POOL_AVG_EN
        h_new    = kc_first ? px_ext : combine(acc_h, px_ext, avg_r);
        v_new    = combine(vbuf[wc], h_new, avg_r);
        result   = avg_r ? dataWidth'(v_new >>> (2 * LP)) : v_new[dataWidth-1:0];
`else
        h_new    = kc_first ? px_ext : max2(acc_h, px_ext);
        v_new    = max2(vbuf[wc], h_new);
        result   = v_new[dataWidth-1:0];
`endif
    end

    // Raster counters, horizontal accumulator and registered result/strobes
    always_ff @(posedge clk) begin
        if (global_rst) begin
            col          <= '0;
            row          <= '0;
            acc_h        <= '0;
            last_r       <= 1'b0;
            bus.data_out <= '0;
            bus.valid_op <= 1'b0;
            bus.end_op   <= 1'b0;
`ifdef POOL_AVG_EN
            avg_r        <= 1'b0;
`endif
        end else begin
            bus.valid_op <= 1'b0;
            bus.end_op   <= last_r;
            last_r       <= 1'b0;
            if (accept) begin
                col <= col_last ? '0 : col + CW'(1);
                if (col_last) begin
                    row <= row_last ? '0 : row + CW'(1);
                end
`ifdef POOL_AVG_EN
                // Mode is latched once per window row block, at its first pixel
                if (col == '0 && kr_first) begin
                    avg_r <= bus.avg_mode;
                end
`endif
                if (in_span) begin
                    acc_h <= h_new;
                    if (kc_last && kr_last) begin
                        bus.valid_op <= 1'b1;
                        bus.data_out <= result;
                        last_r       <= win_last;
                    end
                end
            end
        end
    end

    // Column partials: first window row overwrites, middle rows combine
    always_ff @(posedge clk) begin
        if (!global_rst && accept && in_span && kc_last) begin
            if (kr_first) begin
                vbuf[wc] <= h_new;
            end else if (!kr_last) begin
                vbuf[wc] <= v_new;
            end
        end
    end
endmodule

// File: tb/tb_pool_stream.sv
// Randomized and directed bench for pool_stream: four configurations fed one shared stream,
// each checked cycle by cycle against a frame-image reference model.
`timescale 1ns/1ps
module tb_pool_stream;
    localparam int ND     = 4;
    localparam int MAXPIX = 81;
`ifdef POOL_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic       valid_in = 1'b0;
    logic       avg_mode = 1'b0;
    logic [7:0] data_in = 8'h00;

    logic [7:0] dout [ND];
    logic       vop  [ND];
    logic       eop  [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned WG = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 5 : 9;
        localparam int unsigned PG = (g == 3) ? 4 : 2;
        pool_stream_if #(.dataWidth(8)) bus ();
        assign bus.ce       = ce;
        assign bus.valid_in = valid_in;
        assign bus.data_in  = data_in;
        assign bus.avg_mode = avg_mode;
        assign dout[g]      = bus.data_out;
        assign vop[g]       = bus.valid_op;
        assign eop[g]       = bus.end_op;
        pool_stream #(.dataWidth(8), .W(WG), .P(PG)) dut (
            .clk       (clk),
            .global_rst(rst),
            .bus       (bus)
        );
    end

    function automatic int w_of(int d);
        case (d)
            0:       return 4;
            1:       return 2;
            2:       return 5;
            default: return 9;
        endcase
    endfunction

    function automatic int p_of(int d);
        return (d == 3) ? 4 : 2;
    endfunction

    int         checks = 0;
    int         errors = 0;
    bit         run = 1'b0;
    int         cnt  [ND];
    logic [7:0] img  [ND][MAXPIX];
    bit         mblk [ND];
    bit         ev   [ND];
    bit         ee   [ND];
    bit         pend [ND];
    logic [7:0] ed   [ND];
    logic [7:0] seen [ND][$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Pooled value of one window straight from the stored frame image
    function automatic logic [7:0] win_ref(int d, int br, int bc, bit avg);
        int w  = w_of(d);
        int p  = p_of(d);
        int s  = 0;
        int mx = -1000;
        int v;
        int q;
        for (int i = 0; i < p; i++) begin
            for (int j = 0; j < p; j++) begin
                v = int'($signed(img[d][(br * p + i) * w + bc * p + j]));
                s += v;
                if (v > mx) mx = v;
            end
        end
        if (!avg) return 8'(mx);
        q = s / (p * p);
        if ((s % (p * p) != 0) && (s < 0)) q--;
        return 8'(q);
    endfunction

    // Reference: what each DUT must show after this edge
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            int w, p, nb, r, c;
            if (rst) begin
                cnt[d] = 0; ev[d] = 0; ee[d] = 0; pend[d] = 0; ed[d] = 8'h00; mblk[d] = 0;
            end else begin
                ee[d]   = pend[d];
                pend[d] = 0;
                ev[d]   = 0;
                if (ce && valid_in) begin
                    w  = w_of(d);
                    p  = p_of(d);
                    nb = w / p;
                    r  = cnt[d] / w;
                    c  = cnt[d] % w;
                    img[d][cnt[d]] = data_in;
                    if (c == 0 && r % p == 0) mblk[d] = AVG_EN && avg_mode;
                    if (c % p == p - 1 && r % p == p - 1 && c < nb * p && r < nb * p) begin
                        ev[d] = 1;
                        ed[d] = win_ref(d, r / p, c / p, mblk[d]);
                        if (r / p == nb - 1 && c / p == nb - 1) pend[d] = 1;
                    end
                    cnt[d] = (cnt[d] + 1) % (w * w);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            for (int d = 0; d < ND; d++) begin
                check($sformatf("dut%0d valid_op", d), 32'(vop[d]), 32'(ev[d]));
                check($sformatf("dut%0d end_op", d), 32'(eop[d]), 32'(ee[d]));
                check($sformatf("dut%0d data_out", d), 32'(dout[d]), 32'(ed[d]));
                if (vop[d] === 1'b1) seen[d].push_back(dout[d]);
            end
        end
    end

    task automatic cyc(bit c, bit v, logic [7:0] dt, bit am);
        @(posedge clk);
        #1;
        ce = c; valid_in = v; data_in = dt; avg_mode = am;
    endtask

    task automatic idle(int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00, avg_mode);
    endtask

    task automatic do_reset(int n);
        @(posedge clk);
        #1;
        rst = 1'b1; ce = 1'b0; valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < ND; d++) seen[d].delete();
    endtask

    task automatic expect_list(int d, string tag, int n, logic [7:0] e0, logic [7:0] e1,
                               logic [7:0] e2, logic [7:0] e3);
        logic [7:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        check({tag, " count"}, 32'(seen[d].size()), 32'(n));
        for (int i = 0; i < n && i < seen[d].size(); i++)
            check($sformatf("%s[%0d]", tag, i), 32'(seen[d][i]), 32'(e[i % 4]));
        seen[d].delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;
        do_reset(2);

        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
        idle(3);
        expect_list(0, "w4 max", 4, 8'd5, 8'd7, 8'd13, 8'd15);

        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'(i), 1'b1);
        idle(3);
        if (AVG_EN) expect_list(0, "w4 avg", 4, 8'd2, 8'd4, 8'd10, 8'd12);
        else        expect_list(0, "w4 avg", 4, 8'd5, 8'd7, 8'd13, 8'd15);

        // Two back-to-back frames with a stall slot after every accept
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                cyc(1'b1, 1'b1, 8'(i), 1'b0);
                cyc(i[0], ~i[0], 8'hAA, 1'b1);
            end
        end
        idle(3);
        expect_list(0, "w4 stall", 8, 8'd5, 8'd7, 8'd13, 8'd15);

        do_reset(2);
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
        do_reset(3);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
        idle(3);
        expect_list(0, "w4 after reset", 4, 8'd5, 8'd7, 8'd13, 8'd15);

        do_reset(2);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'(8'hFF - i), 1'b0);
        idle(3);
        expect_list(1, "w2 max", 1, 8'hFF, 8'h00, 8'h00, 8'h00);
        do_reset(2);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 8'(8'hFF - i), 1'b1);
        idle(3);
        if (AVG_EN) expect_list(1, "w2 avg", 1, 8'hFD, 8'h00, 8'h00, 8'h00);
        else        expect_list(1, "w2 avg", 1, 8'hFF, 8'h00, 8'h00, 8'h00);

        do_reset(2);
        for (int i = 0; i < 25; i++) cyc(1'b1, 1'b1, 8'(i), 1'b0);
        idle(3);
        expect_list(2, "w5 max", 4, 8'd6, 8'd8, 8'd16, 8'd18);

        do_reset(2);
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            rst      = ($urandom_range(0, 399) == 0);
            ce       = ($urandom_range(0, 3) != 0);
            valid_in = ($urandom_range(0, 3) != 0);
            data_in  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) avg_mode = ~avg_mode;
        end
        rst = 1'b0;
        idle(4);
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
